// File: rtl/draw_sprite_if.sv
// vga_if: one pixel of the VGA timing/colour stream passed between drawing stages.
interface vga_if;
   logic [11:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [11:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;
   modport vga_in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport vga_out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_sprite.sv
// draw_sprite: overlays an animated, colour-keyed sprite from a synchronous ROM onto the VGA stream.
module draw_sprite #(
   parameter int          SPRITE_W  = 64,
   parameter int          SPRITE_H  = 64,
   parameter int          FRAMES    = 4,
   parameter int          FRAME_DIV = 8,
   parameter logic [11:0] KEY_RGB   = 12'hF0F,
   parameter int          ADDR_W    = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [11:0]       xpos,
   input  logic [11:0]       ypos,
   input  logic              anim_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_data,
   vga_if.vga_in             vga_in,
   vga_if.vga_out            vga_out
);
   localparam int IW = FRAMES > 1 ? $clog2(FRAMES) : 1;
   localparam int DW = FRAME_DIV > 1 ? $clog2(FRAME_DIV) : 1;
   localparam int FRAME_PIX = SPRITE_W * SPRITE_H;
   logic [11:0]       x_lat, y_lat;
   logic [DW-1:0]     div_cnt;
   logic [IW-1:0]     anim_idx;
   logic              vblnk_d;
   logic              rise;
   logic              hit, hit_s1;
   logic [12:0]       x_end, y_end;
   logic [11:0]       dx, dy;
   logic [ADDR_W-1:0] addr_nxt;
   logic [11:0]       vcount_s1, hcount_s1, rgb_s1;
   logic              vsync_s1, vblnk_s1, hsync_s1, hblnk_s1;
   logic              draw;
   always_comb begin
      rise     = vga_in.vblnk & ~vblnk_d;
      // 13-bit bounds so a sprite near the right/bottom edge never wraps to 0
      x_end    = {1'b0, x_lat} + 13'(SPRITE_W);
      y_end    = {1'b0, y_lat} + 13'(SPRITE_H);
      hit      = (vga_in.hcount >= x_lat) && ({1'b0, vga_in.hcount} < x_end) &&
                 (vga_in.vcount >= y_lat) && ({1'b0, vga_in.vcount} < y_end);
      dx       = vga_in.hcount - x_lat;
      dy       = vga_in.vcount - y_lat;
      addr_nxt = hit ? ADDR_W'(anim_idx) * ADDR_W'(FRAME_PIX) + ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(dx) : '0;
      draw     = hit_s1 & ~hblnk_s1 & ~vblnk_s1 & (rom_data != KEY_RGB);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         x_lat      <= '0;
         y_lat      <= '0;
         div_cnt    <= '0;
         anim_idx   <= '0;
         vblnk_d    <= 1'b0;
         hit_s1     <= 1'b0;
         rom_addr   <= '0;
         vcount_s1  <= '0;
         vsync_s1   <= 1'b0;
         vblnk_s1   <= 1'b0;
         hcount_s1  <= '0;
         hsync_s1   <= 1'b0;
         hblnk_s1   <= 1'b0;
         rgb_s1     <= '0;
         vga_out.vcount <= '0;
         vga_out.vsync  <= 1'b0;
         vga_out.vblnk  <= 1'b0;
         vga_out.hcount <= '0;
         vga_out.hsync  <= 1'b0;
         vga_out.hblnk  <= 1'b0;
         vga_out.rgb    <= '0;
      end else begin
         vblnk_d <= vga_in.vblnk;
         if (rise) begin
            x_lat <= xpos;
            y_lat <= ypos;
         end
         if (rise && anim_en) begin
            if (div_cnt == DW'(FRAME_DIV - 1)) begin
               div_cnt  <= '0;
               anim_idx <= (anim_idx == IW'(FRAMES - 1)) ? '0 : anim_idx + 1'b1;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end
         hit_s1    <= hit;
         rom_addr  <= addr_nxt;
         vcount_s1 <= vga_in.vcount;
         vsync_s1  <= vga_in.vsync;
         vblnk_s1  <= vga_in.vblnk;
         hcount_s1 <= vga_in.hcount;
         hsync_s1  <= vga_in.hsync;
         hblnk_s1  <= vga_in.hblnk;
         rgb_s1    <= vga_in.rgb;
         vga_out.vcount <= vcount_s1;
         vga_out.vsync  <= vsync_s1;
         vga_out.vblnk  <= vblnk_s1;
         vga_out.hcount <= hcount_s1;
         vga_out.hsync  <= hsync_s1;
         vga_out.hblnk  <= hblnk_s1;
         vga_out.rgb    <= draw ? rom_data : rgb_s1;
      end
   end
endmodule

// File: tb/tb_draw_sprite.sv
// tb_draw_sprite: directed checks of draw_sprite latency, hit/address, keying, latching and animation.
module tb_draw_sprite;
   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] xpos, ypos, rom_data;
   logic        anim_en;
   logic [13:0] rom_addr;
   int          n_tests = 0;
   int          n_fail = 0;
   vga_if vin();
   vga_if vout();
   draw_sprite dut (
      .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .anim_en(anim_en),
      .rom_addr(rom_addr), .rom_data(rom_data), .vga_in(vin), .vga_out(vout)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic set_pix(input int h, input int v, input logic [11:0] c);
      vin.hcount = 12'(h);
      vin.vcount = 12'(v);
      vin.rgb    = c;
      vin.hsync  = 1'b0;
      vin.vsync  = 1'b0;
      vin.hblnk  = 1'b0;
      vin.vblnk  = 1'b0;
   endtask
   // pixel in, ROM answers on the following cycle, colour checked at the output
   task automatic probe(input string tag, input int h, input int v, input logic hb,
                        input logic [11:0] romd, input int exp_addr, input logic [11:0] exp_rgb);
      set_pix(h, v, 12'h555);
      vin.hblnk = hb;
      step();
      check({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
      rom_data = romd;
      set_pix(4000, 4000, 12'h000);
      step();
      check({tag, "_rgb"}, 32'(vout.rgb), 32'(exp_rgb));
   endtask
   task automatic vpulse(input int n);
      for (int i = 0; i < n; i++) begin
         set_pix(4000, 4000, 12'h000);
         vin.vblnk = 1'b1;
         step();
         vin.vblnk = 1'b0;
         step();
      end
   endtask
   initial begin
      rst = 1'b1;
      xpos = 12'd200;
      ypos = 12'd100;
      anim_en = 1'b0;
      rom_data = 12'h000;
      set_pix(77, 33, 12'hFFF);
      vin.hsync = 1'b1;
      step();
      step();
      check("rst_rgb", 32'(vout.rgb), 32'h0);
      check("rst_hcount", 32'(vout.hcount), 32'h0);
      check("rst_hsync", 32'(vout.hsync), 32'h0);
      check("rst_addr", 32'(rom_addr), 32'h0);
      rst = 1'b0;
      set_pix(100, 50, 12'h123);
      vin.hsync = 1'b1;
      step();
      set_pix(4000, 4000, 12'h000);
      check("lat_1clk", 32'(vout.hcount), 32'h0);
      step();
      check("lat_hcount", 32'(vout.hcount), 32'd100);
      check("lat_vcount", 32'(vout.vcount), 32'd50);
      check("lat_hsync", 32'(vout.hsync), 32'h1);
      check("lat_rgb", 32'(vout.rgb), 32'h123);
      probe("pre_latch", 10, 5, 1'b0, 12'hABC, 330, 12'hABC);
      vpulse(1);
      check("x_lat", 32'(dut.x_lat), 32'd200);
      check("y_lat", 32'(dut.y_lat), 32'd100);
      probe("hit", 210, 105, 1'b0, 12'hABC, 330, 12'hABC);
      probe("key", 210, 105, 1'b0, 12'hF0F, 330, 12'h555);
      probe("x_out", 264, 105, 1'b0, 12'hABC, 0, 12'h555);
      probe("x_last", 263, 105, 1'b0, 12'hABC, 383, 12'hABC);
      probe("y_out", 210, 164, 1'b0, 12'hABC, 0, 12'h555);
      probe("corner", 200, 100, 1'b0, 12'hABC, 0, 12'hABC);
      probe("hblnk", 210, 105, 1'b1, 12'hABC, 330, 12'h555);
      xpos = 12'd300;
      probe("mid_move", 210, 105, 1'b0, 12'hABC, 330, 12'hABC);
      vpulse(1);
      probe("moved_new", 310, 105, 1'b0, 12'hABC, 330, 12'hABC);
      probe("moved_old", 210, 105, 1'b0, 12'hABC, 0, 12'h555);
      xpos = 12'd4090;
      vpulse(1);
      probe("nowrap", 2, 105, 1'b0, 12'hABC, 0, 12'h555);
      probe("right_edge", 4095, 105, 1'b0, 12'hABC, 325, 12'hABC);
      xpos = 12'd200;
      anim_en = 1'b1;
      vpulse(7);
      probe("anim_7", 200, 100, 1'b0, 12'hABC, 0, 12'hABC);
      vpulse(1);
      probe("anim_8", 200, 100, 1'b0, 12'hABC, 4096, 12'hABC);
      vpulse(8);
      probe("anim_16", 201, 100, 1'b0, 12'hABC, 8193, 12'hABC);
      vpulse(16);
      probe("anim_32", 201, 100, 1'b0, 12'hABC, 1, 12'hABC);
      vpulse(8);
      anim_en = 1'b0;
      vpulse(16);
      probe("anim_hold", 201, 100, 1'b0, 12'hABC, 4097, 12'hABC);
      anim_en = 1'b1;
      vpulse(7);
      probe("div_hold", 201, 100, 1'b0, 12'hABC, 4097, 12'hABC);
      vpulse(1);
      probe("div_resume", 201, 100, 1'b0, 12'hABC, 8193, 12'hABC);
      set_pix(210, 105, 12'h555);
      rom_data = 12'hABC;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_rgb", 32'(vout.rgb), 32'h0);
      check("mid_rst_hcount", 32'(vout.hcount), 32'h0);
      check("mid_rst_addr", 32'(rom_addr), 32'h0);
      check("mid_rst_anim", 32'(dut.anim_idx), 32'h0);
      check("mid_rst_xlat", 32'(dut.x_lat), 32'h0);
      check("mid_rst_ylat", 32'(dut.y_lat), 32'h0);
      probe("post_rst", 10, 5, 1'b0, 12'hABC, 330, 12'hABC);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
